// File: rtl/logic_pkg.sv
// Shared definitions for the 4-bit gate front end: operand width and opcode encoding.
package logic_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_NAND = 2'b10,
        OP_XOR  = 2'b11
    } op_e;

endpackage

// File: rtl/logic_gates.sv
// 4-bit gate library: one bitwise gate per module, fixed width.
module and_gate (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y
);
    assign y = a & b;
endmodule

module or_gate (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y
);
    assign y = a | b;
endmodule

module nand_gate (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y
);
    assign y = ~(a & b);
endmodule

module xor_gate (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y
);
    assign y = a ^ b;
endmodule

// File: rtl/logic_sel.sv
// Combinational result selector: all four gates evaluate in parallel, op picks one.
module logic_sel
    import logic_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] y
);

    logic [DATA_W-1:0] y_and;
    logic [DATA_W-1:0] y_or;
    logic [DATA_W-1:0] y_nand;
    logic [DATA_W-1:0] y_xor;

    and_gate  u_and  (.a(a), .b(b), .y(y_and));
    or_gate   u_or   (.a(a), .b(b), .y(y_or));
    nand_gate u_nand (.a(a), .b(b), .y(y_nand));
    xor_gate  u_xor  (.a(a), .b(b), .y(y_xor));

    // NOTE: a default assignment ahead of the case keeps this block free of latches.
    always_comb begin
        y = y_and;
        case (op_e'(op))
            OP_AND:  y = y_and;
            OP_OR:   y = y_or;
            OP_NAND: y = y_nand;
            OP_XOR:  y = y_xor;
            default: y = y_and;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline around logic_sel: operand register, result register
// with zero flag, and a wrapping count of output transfers.
module logic_unit_pipe #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_op,
    output logic              out_zero,
    input  logic              clr_count,
    output logic [CNT_W-1:0]  op_count
);

    if (DATA_W != logic_pkg::DATA_W) begin : g_width_check
        $error("logic_unit_pipe: DATA_W must match the 4-bit gate library");
    end

    logic              s1_valid;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic [1:0]        s1_op;
    logic [DATA_W-1:0] sel_y;
    logic              in_xfer;
    logic              s1_adv;
    logic              out_xfer;

    // Stage 1 may refill in the same cycle it hands its entry to stage 2.
    assign in_ready = !reset && (!s1_valid || !out_valid || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign s1_adv   = s1_valid && (!out_valid || out_ready);
    assign out_xfer = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // NOTE: operand registers carry no reset; s1_valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            s1_a  <= in_a;
            s1_b  <= in_b;
            s1_op <= in_op;
        end
    end

    logic_sel u_sel (
        .a  (s1_a),
        .b  (s1_b),
        .op (s1_op),
        .y  (sel_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_op    <= '0;
            out_zero  <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            out_data  <= sel_y;
            out_op    <= s1_op;
            out_zero  <= (sel_y == '0);
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

    // A clear coinciding with a transfer counts that transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_count <= '0;
        end else if (clr_count) begin
            op_count <= out_xfer ? CNT_W'(1) : '0;
        end else if (out_xfer) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: driver pushes expected results on accept,
// an independent monitor pops and compares on every output transfer.
module tb_logic_unit_pipe;

    localparam int DW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_op = '0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [1:0]    out_op;
    logic          out_zero;
    logic          clr_count = 1'b0;
    logic [CW-1:0] op_count;

    logic_unit_pipe #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_op    (out_op),
        .out_zero  (out_zero),
        .clr_count (clr_count),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] data;
        int            cyc;
        bit            lat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   acc_n = 0;
    int   xfer_n = 0;
    int   cnt_model = 0;
    bit   lat_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] ref_gate(input logic [1:0] op, input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return ~(a & b);
            default: return a ^ b;
        endcase
    endfunction

    // One clock of stimulus; inputs change on the falling edge, checks settle 1ns later.
    task automatic cycle(input bit v, input logic [1:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input bit ordy, input bit clr,
                         input bit rst, output bit acc);
        @(negedge clk);
        reset = rst; in_valid = v; in_op = op; in_a = a; in_b = b;
        out_ready = ordy; clr_count = clr;
        #1;
        acc = 1'b0;
        if (rst) begin
            check("in_ready_in_reset", in_ready, 0);
            sb.delete();
            acc_n = 0;
            xfer_n = 0;
        end else begin
            check("in_ready", in_ready, !((acc_n - xfer_n) == 2 && !ordy));
            if (v && in_ready) begin
                sb.push_back('{op: op, data: ref_gate(op, a, b), cyc: cyc, lat: lat_mode});
                acc_n++;
                acc = 1'b1;
            end
        end
    endtask

    task automatic idle(input bit ordy);
        bit acc;
        cycle(1'b0, 2'd0, '0, '0, ordy, 1'b0, 1'b0, acc);
    endtask

    task automatic send(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bit acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) cycle(1'b1, op, a, b, 1'b1, 1'b0, 1'b0, acc);
        if (!acc) check("send_timeout", 0, 1);
    endtask

    // Empty the pipeline, then one idle cycle so op_count reflects the last transfer.
    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            idle(1'b1);
            t++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        idle(1'b1);
    endtask

    // Monitor: compares every output transfer against the scoreboard head.
    initial begin
        bit            stall = 1'b0;
        bit            xfer;
        logic [DW-1:0] hd;
        logic [1:0]    ho;
        logic          hz;
        exp_t          e;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                cnt_model = 0;
                stall = 1'b0;
            end else begin
                check("op_count", op_count, cnt_model);
                if (stall) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, hd);
                    check("hold_op", out_op, ho);
                    check("hold_zero", out_zero, hz);
                end
                xfer = out_valid && out_ready;
                if (xfer) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_output: got data %0h op %0d with nothing expected (cycle %0d)",
                                 out_data, out_op, cyc);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_op", out_op, e.op);
                        check("out_zero", out_zero, e.data == 0);
                        if (e.lat) check("latency", cyc - e.cyc, 2);
                    end
                    xfer_n++;
                end
                if (clr_count) cnt_model = xfer ? 1 : 0;
                else if (xfer) cnt_model = (cnt_model + 1) % 256;
                stall = out_valid && !out_ready;
                hd = out_data; ho = out_op; hz = out_zero;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            acc;
        int            idx;
        logic [1:0]    bp_op [4];
        logic [DW-1:0] bp_a  [4];
        logic [DW-1:0] bp_b  [4];

        // Reset held two cycles with in_valid asserted.
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 2'd3, 4'hF, 4'h1, 1'b1, 1'b0, 1'b1, acc);
            if (i > 0) begin
                check("reset_out_valid", out_valid, 0);
                check("reset_op_count", op_count, 0);
            end
        end
        idle(1'b1);

        // Each opcode back to back, then zero-flag cases; fixed latency of 2.
        lat_mode = 1'b1;
        for (int op = 0; op < 4; op++) send(2'(op), 4'b1100, 4'b1010);
        send(2'd3, 4'hA, 4'hA);
        send(2'd0, 4'hF, 4'h1);
        drain();
        lat_mode = 1'b0;

        // Backpressure: 5 cycles with out_ready low, 4 ops queued.
        for (int i = 0; i < 4; i++) begin
            bp_op[i] = 2'($urandom_range(0, 3));
            bp_a[i]  = 4'($urandom);
            bp_b[i]  = 4'($urandom);
        end
        idx = 0;
        for (int t = 0; t < 5; t++) begin
            cycle(idx < 4, bp_op[idx % 4], bp_a[idx % 4], bp_b[idx % 4], 1'b0, 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        check("bp_accepts", idx, 2);
        for (int t = 0; t < 20 && idx < 4; t++) begin
            cycle(1'b1, bp_op[idx], bp_a[idx], bp_b[idx], 1'b1, 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        check("bp_all_accepted", idx, 4);
        drain();

        // Counter wrap and clear.
        cycle(1'b0, 2'd0, '0, '0, 1'b1, 1'b0, 1'b1, acc);
        for (int i = 0; i < 255; i++) send(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
        drain();
        check("count_255", op_count, 255);
        send(2'd1, 4'h3, 4'h4);
        drain();
        check("count_wrap", op_count, 0);
        for (int i = 0; i < 3; i++) send(2'd2, 4'h5, 4'h6);
        drain();
        check("count_3", op_count, 3);
        cycle(1'b1, 2'd0, 4'h9, 4'h9, 1'b0, 1'b0, 1'b0, acc);
        for (int t = 0; t < 10 && !out_valid; t++) idle(1'b0);
        cycle(1'b0, 2'd0, '0, '0, 1'b1, 1'b1, 1'b0, acc);
        idle(1'b0);
        check("count_clr_xfer", op_count, 1);
        cycle(1'b0, 2'd0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
        idle(1'b0);
        check("count_clr_only", op_count, 0);

        // Reset with both stages full: stale results must never appear.
        for (int t = 0; t < 6; t++) cycle(1'b1, 2'd1, 4'h7, 4'h8, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 2'd1, 4'h7, 4'h8, 1'b1, 1'b0, 1'b1, acc);
        idle(1'b1);
        check("flush_out_valid", out_valid, 0);
        idle(1'b1);
        check("flush_out_valid_2", out_valid, 0);
        repeat (3) idle(1'b1);

        // Randomized traffic with random backpressure and occasional clears.
        for (int t = 0; t < 400; t++) begin
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, 1'b0, acc);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
